// File: rtl/alu_arbiter.sv
// alu_arbiter: shares a single combinational ALU between two requesters.
// Round-robin grant in IDLE, operands registered into the ALU for one EXEC
// cycle, result/zero captured and returned on a valid/ready response channel
// tagged with the owning requester.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OP_W-1:0]  req1_op,
    output logic [WIDTH-1:0] alu_ope1,
    output logic [WIDTH-1:0] alu_ope2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_resultado,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_resultado,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Also serves as the id of the in-flight operation: it is rewritten with
    // the winner on every accept, so it always names the current owner.
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] ope1_q, ope1_d;
    logic [WIDTH-1:0] ope2_q, ope2_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic             any_valid;
    logic             grant;
    logic             accept;

    // Round-robin grant: a lone requester wins, a tie goes to the port not served last
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
        accept     = (state_q == IDLE) && any_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    // Next-state and datapath update for the IDLE -> EXEC -> RESP sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ope1_d       = ope1_q;
        ope2_d       = ope2_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_zero_d   = rsp_zero_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = EXEC;
                    last_grant_d = grant;
                    ope1_d       = grant ? req1_a  : req0_a;
                    ope2_d       = grant ? req1_b  : req0_b;
                    op_d         = grant ? req1_op : req0_op;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = last_grant_q;
                rsp_res_d   = alu_resultado;
                rsp_zero_d  = alu_zero;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; async reset drops any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            ope1_q       <= '0;
            ope2_q       <= '0;
            op_q         <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ope1_q       <= ope1_d;
            ope2_q       <= ope2_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_ope1      = ope1_q;
    assign alu_ope2      = ope2_q;
    assign alu_op        = op_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_resultado = rsp_res_q;
    assign rsp_zero      = rsp_zero_q;

endmodule
